keypad_entry_seq: RTL and testbench
===================================

KEYPAD_ENTRY_SEQ -- requirements
Module: keypad_entry_seq

Interface
REQ-001 SHALL have parameter DIGITS, default 4: key presses collected per entry, range 1..7.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles after a press before the entry is abandoned.
REQ-003 SHALL have parameter HOLD_CYCLES, default 4: cycles the completed mask is presented downstream.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 8: stable cycles required per key; used only when debounce is compiled in.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port keys, input, 10 bits: raw key levels; bit n is digit n.
REQ-008 SHALL have port clr, input, 1 bit: synchronous entry abort.
REQ-009 SHALL have port key_mask, output, 10 bits: sticky set of digits pressed, driving the lock checker's in0..in9.
REQ-010 SHALL have port entry_valid, output, 1 bit: high while key_mask holds a completed entry.
REQ-011 SHALL have port press_cnt, output, 3 bits: presses accepted in the current entry.
REQ-012 SHALL have port entry_timeout, output, 1 bit: one-cycle pulse when an entry is abandoned.
REQ-013 SHALL have port multi_key_err, output, 1 bit: one-cycle pulse when more than one key rises together.
REQ-014 SHALL have port busy, output, 1 bit: high in COLLECT or PRESENT.

Function
REQ-015 SHALL register keys once, giving keys_q; a press event occurs when keys_q == 0 and keys is one-hot.
REQ-016 SHALL ignore, and pulse multi_key_err for, any cycle where keys_q == 0 and popcount(keys) >= 2.
REQ-017 SHALL implement the states IDLE, COLLECT and PRESENT.
REQ-018 In IDLE, a press SHALL set the key's bit in key_mask, set press_cnt = 1 and go to COLLECT; if DIGITS == 1 it SHALL go to PRESENT instead.
REQ-019 In COLLECT, a press SHALL OR its bit into key_mask, increment press_cnt and reset the timeout counter.
REQ-020 A repeated digit SHALL count as a press, with key_mask unchanged, so the downstream checker sees fewer than DIGITS bits.
REQ-021 When press_cnt reaches DIGITS, the FSM SHALL enter PRESENT on the next edge, with entry_valid high from that cycle.
REQ-022 PRESENT SHALL last exactly HOLD_CYCLES cycles, then clear key_mask and press_cnt, drop entry_valid and go to IDLE.
REQ-023 Presses in PRESENT SHALL be ignored; a press on the exit cycle SHALL also be ignored.
REQ-024 In COLLECT, TIMEOUT_CYCLES cycles with no press SHALL clear key_mask and press_cnt, pulse entry_timeout and go to IDLE.
REQ-025 clr SHALL, from any state, go to IDLE, clear key_mask and press_cnt and suppress entry_timeout; clr takes priority over a same-cycle press.
REQ-026 The timeout counter SHALL be sized clog2(TIMEOUT_CYCLES+1) bits and saturate, never wrap.

Reset
REQ-027 rst SHALL force IDLE and clear key_mask = 0, press_cnt = 0, keys_q = 0 and the counters; entry_valid, entry_timeout, multi_key_err and busy SHALL be 0.
REQ-028 rst asserted mid-entry or mid-PRESENT SHALL discard the entry with no entry_timeout pulse; rst takes priority over clr.

Configuration
REQ-029 With KEYPAD_DEBOUNCE_EN defined, each key bit SHALL pass through a debouncer; a level change SHALL be accepted only after DEBOUNCE_CYCLES consecutive stable samples, adding DEBOUNCE_CYCLES+1 cycles of latency.
REQ-030 Without KEYPAD_DEBOUNCE_EN, keys SHALL feed keys_q directly with one cycle of latency, and DEBOUNCE_CYCLES SHALL be unused.

Structure
REQ-031 Package keypad_pkg SHALL hold KEY_W = 10 and the FSM state enum (IDLE, COLLECT, PRESENT).
REQ-032 The debouncer SHALL be sub-module key_debounce (one bit, parameter DEBOUNCE_CYCLES), instantiated 10 times under KEYPAD_DEBOUNCE_EN.

Verification (debounce off unless stated)
REQ-033 Press 1,2,3,4 singly, with release between each -> key_mask = 10'h01E, entry_valid high for exactly 4 cycles, then key_mask = 0.
REQ-034 Press 1,1,2,3 -> press_cnt reaches 4, key_mask = 10'h00E, entry_valid asserted.
REQ-035 Press 5, then no input for 1000 cycles -> one entry_timeout pulse, key_mask = 0, busy = 0.
REQ-036 keys = 10'h006 from all-released -> multi_key_err pulse, press_cnt stays 0.
REQ-037 Press 7,8, then clr in the same cycle as press 9 -> IDLE, key_mask = 0, no entry_timeout.
REQ-038 With KEYPAD_DEBOUNCE_EN: key 3 glitching high for 5 cycles -> no press; key 3 held for 12 cycles -> one press.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared definitions for the keypad entry sequencer.
//   KEY_W   : number of keypad keys (digits 0..9)
//   state_t : entry FSM states (IDLE, COLLECT, PRESENT)
package keypad_pkg;

  localparam int KEY_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce -- single-bit level debouncer.
// The output follows the input only after the input has held its new level
// for DEBOUNCE_CYCLES consecutive samples; total latency DEBOUNCE_CYCLES+1.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (output and counter to 0)
//   d   : raw level
//   q   : debounced level
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int            CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          d_p0;
  logic [CW-1:0] cnt;

  // stage p0: input sample; stage p1: stability count and accepted level
  always_ff @(posedge clk) begin
    if (rst) begin
      d_p0 <= 1'b0;
      q    <= 1'b0;
      cnt  <= '0;
    end else begin
      d_p0 <= d;
      if (d_p0 != q) begin
        if (cnt == CLAST) begin
          q   <= d_p0;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/keypad_entry_seq.sv
// keypad_entry_seq -- collects DIGITS single-key presses into a sticky
// digit mask, presents it for HOLD_CYCLES, and abandons stale entries.
// Optional build macro: KEYPAD_DEBOUNCE_EN inserts a key_debounce per key.
// Ports:
//   clk           : rising-edge clock
//   rst           : synchronous active-high reset
//   keys          : raw key levels, bit n = digit n
//   clr           : synchronous entry abort
//   key_mask      : sticky set of digits pressed in the current entry
//   entry_valid   : key_mask holds a completed entry
//   press_cnt     : presses accepted in the current entry
//   entry_timeout : one-cycle pulse when an entry is abandoned
//   multi_key_err : one-cycle pulse when several keys rise together
//   busy          : FSM is in COLLECT or PRESENT
module keypad_entry_seq
  import keypad_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int HOLD_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] keys,
  input  logic             clr,
  output logic [KEY_W-1:0] key_mask,
  output logic             entry_valid,
  output logic [2:0]       press_cnt,
  output logic             entry_timeout,
  output logic             multi_key_err,
  output logic             busy
);

  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam int            HW    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);

  if (DIGITS < 1 || DIGITS > 7 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      DEBOUNCE_CYCLES < 1) begin : g_param_chk
    $error("keypad_entry_seq: parameter out of range");
  end

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TMAX) ? v : v + 1'b1;
  endfunction

  logic [KEY_W-1:0] key_src;
  logic [KEY_W-1:0] keys_q;
  logic             press;
  logic             multi;
  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             abandon;
  logic             finish;
  logic [KEY_W-1:0] mask_r;
  logic [2:0]       cnt_r;
  logic [TW-1:0]    tcnt;
  logic [HW-1:0]    hcnt;
  logic             to_r;
  logic             mk_r;

`ifdef KEYPAD_DEBOUNCE_EN
  for (genvar i = 0; i < KEY_W; i++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk(clk),
      .rst(rst),
      .d  (keys[i]),
      .q  (key_src[i])
    );
  end
`else
  assign key_src = keys;
`endif

  // A press is a rising edge out of the all-released state; a key held
  // down (keys_q != 0) blocks any further press until everything is up.
  assign press = (keys_q == '0) && $onehot(key_src);
  assign multi = (keys_q == '0) && ($countones(key_src) >= 2);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; clr overrides everything, including a same-cycle press
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    abandon   = 1'b0;
    finish    = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, COLLECT: begin
          if (press) begin
            accept    = 1'b1;
            state_nxt = ((int'(cnt_r) + 1) == DIGITS) ? PRESENT : COLLECT;
          end else if (state == COLLECT && sat_inc(tcnt) == TMAX) begin
            abandon   = 1'b1;
            state_nxt = IDLE;
          end
        end
        PRESENT: begin
          if (hcnt == HLAST) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered key sample, entry datapath, counters and event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q <= '0;
      mask_r <= '0;
      cnt_r  <= '0;
      tcnt   <= '0;
      hcnt   <= '0;
      to_r   <= 1'b0;
      mk_r   <= 1'b0;
    end else begin
      keys_q <= key_src;
      to_r   <= abandon;
      mk_r   <= multi;
      if (clr || abandon || finish) begin
        mask_r <= '0;
        cnt_r  <= '0;
        tcnt   <= '0;
        hcnt   <= '0;
      end else begin
        if (accept) begin
          mask_r <= mask_r | key_src;
          cnt_r  <= cnt_r + 3'd1;
          tcnt   <= '0;
        end else if (state == COLLECT) begin
          tcnt <= sat_inc(tcnt);
        end
        hcnt <= (state == PRESENT) ? hcnt + 1'b1 : '0;
      end
    end
  end

  // Output decode
  always_comb begin
    key_mask      = mask_r;
    press_cnt     = cnt_r;
    entry_valid   = (state == PRESENT);
    busy          = (state != IDLE);
    entry_timeout = to_r;
    multi_key_err = mk_r;
  end

endmodule

// File: tb/tb_keypad_entry_seq.sv
// tb_keypad_entry_seq -- self-checking bench for keypad_entry_seq.
// Directed scenarios plus randomized key/clr/rst traffic, compared every
// cycle against an entry-level reference model kept in this file.
module tb_keypad_entry_seq;
  import keypad_pkg::*;

  localparam int DIGITS          = 4;
  localparam int TIMEOUT_CYCLES  = 1000;
  localparam int HOLD_CYCLES     = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic [KEY_W-1:0] keys = '0;
  logic [KEY_W-1:0] key_mask;
  logic             entry_valid;
  logic [2:0]       press_cnt;
  logic             entry_timeout;
  logic             multi_key_err;
  logic             busy;

  always #5 clk = ~clk;

  keypad_entry_seq #(
    .DIGITS         (DIGITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .keys         (keys),
    .clr          (clr),
    .key_mask     (key_mask),
    .entry_valid  (entry_valid),
    .press_cnt    (press_cnt),
    .entry_timeout(entry_timeout),
    .multi_key_err(multi_key_err),
    .busy         (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int ev_seen = 0;
  int to_seen = 0;
  bit use_model = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: an entry is a list of accepted presses; it is either
  // being collected, being presented (with a countdown), or absent.
  bit               m_coll, m_pres, m_to, m_mk;
  int               m_cnt, m_quiet, m_hold;
  logic [KEY_W-1:0] m_mask, m_prev;

  task automatic model_clear();
    m_coll = 0; m_pres = 0; m_mask = '0; m_cnt = 0; m_quiet = 0; m_hold = 0;
  endtask

  task automatic model_edge(input logic [KEY_W-1:0] k, input bit c, input bit r);
    int ones;
    ones = $countones(k);
    if (r) begin
      model_clear();
      m_to = 0; m_mk = 0; m_prev = '0;
      return;
    end
    m_mk = (m_prev == '0) && (ones >= 2);
    m_to = 0;
    if (c) begin
      model_clear();
    end else if (m_pres) begin
      m_hold--;
      if (m_hold == 0) model_clear();
    end else if (m_prev == '0 && ones == 1) begin
      m_mask |= k;
      m_cnt++;
      m_quiet = 0;
      if (m_cnt == DIGITS) begin
        m_pres = 1; m_coll = 0; m_hold = HOLD_CYCLES;
      end else begin
        m_coll = 1;
      end
    end else if (m_coll) begin
      m_quiet++;
      if (m_quiet == TIMEOUT_CYCLES) begin
        model_clear();
        m_to = 1;
      end
    end
    m_prev = k;
  endtask

  task automatic step(input logic [KEY_W-1:0] k, input bit c, input bit r);
    keys = k; clr = c; rst = r;
    @(posedge clk);
    model_edge(k, c, r);
    #1;
    if (entry_valid)   ev_seen++;
    if (entry_timeout) to_seen++;
    if (use_model) begin
      check("key_mask",      32'(key_mask),      32'(m_mask));
      check("press_cnt",     32'(press_cnt),     32'(m_cnt));
      check("entry_valid",   32'(entry_valid),   32'(m_pres));
      check("busy",          32'(busy),          32'(m_coll | m_pres));
      check("entry_timeout", 32'(entry_timeout), 32'(m_to));
      check("multi_key_err", 32'(multi_key_err), 32'(m_mk));
    end
  endtask

  task automatic press(input int d);
    step(KEY_W'(1) << d, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [KEY_W-1:0] k;
    int r;
    bit c, rr;

`ifdef KEYPAD_DEBOUNCE_EN
    use_model = 1'b0;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(KEY_W'(8), 1'b0, 1'b0);
    idle(30);
    check("glitch_cnt",  32'(press_cnt), 32'd0);
    check("glitch_busy", 32'(busy),      32'd0);
    for (int i = 0; i < 12; i++) step(KEY_W'(8), 1'b0, 1'b0);
    idle(30);
    check("held_cnt",  32'(press_cnt), 32'd1);
    check("held_mask", 32'(key_mask),  32'h008);
    check("held_busy", 32'(busy),      32'd1);
`else
    // reset state
    step('0, 1'b0, 1'b1);
    step(KEY_W'(3), 1'b0, 1'b1);
    check("rst_mask",  32'(key_mask),      32'd0);
    check("rst_cnt",   32'(press_cnt),     32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_multi", 32'(multi_key_err), 32'd0);
    step('0, 1'b0, 1'b0);

    // 1,2,3,4 -> mask 0x01E presented for exactly HOLD_CYCLES
    ev_seen = 0;
    press(1); press(2); press(3);
    step(KEY_W'(1) << 4, 1'b0, 1'b0);
    check("seq_mask",  32'(key_mask),    32'h01E);
    check("seq_valid", 32'(entry_valid), 32'd1);
    idle(8);
    check("seq_hold",  32'(ev_seen),  32'd4);
    check("seq_clear", 32'(key_mask), 32'd0);

    // repeated digit counts but does not add a bit
    press(1); press(1); press(2);
    step(KEY_W'(1) << 3, 1'b0, 1'b0);
    check("rep_cnt",   32'(press_cnt),   32'd4);
    check("rep_mask",  32'(key_mask),    32'h00E);
    check("rep_valid", 32'(entry_valid), 32'd1);
    idle(6);

    // abandoned entry times out once
    to_seen = 0;
    press(5);
    idle(TIMEOUT_CYCLES + 5);
    check("to_pulses", 32'(to_seen),  32'd1);
    check("to_mask",   32'(key_mask), 32'd0);
    check("to_busy",   32'(busy),     32'd0);

    // two keys rising together
    step(KEY_W'(6), 1'b0, 1'b0);
    check("multi_err", 32'(multi_key_err), 32'd1);
    check("multi_cnt", 32'(press_cnt),     32'd0);
    idle(2);

    // clr beats a same-cycle press and suppresses the timeout
    to_seen = 0;
    press(7); press(8);
    step(KEY_W'(1) << 9, 1'b1, 1'b0);
    check("clr_busy", 32'(busy),      32'd0);
    check("clr_mask", 32'(key_mask),  32'd0);
    check("clr_cnt",  32'(press_cnt), 32'd0);
    idle(TIMEOUT_CYCLES + 5);
    check("clr_no_to", 32'(to_seen), 32'd0);

    // rst mid-PRESENT discards the entry
    press(0); press(2); press(3);
    step(KEY_W'(1) << 6, 1'b0, 1'b0);
    step('0, 1'b1, 1'b1);
    check("rstp_valid", 32'(entry_valid), 32'd0);
    check("rstp_mask",  32'(key_mask),    32'd0);
    idle(3);

    // randomized traffic against the model
    k = '0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      k = '0;
      else if (r < 85) k = KEY_W'(1) << $urandom_range(0, KEY_W - 1);
      else if (r < 92) k = KEY_W'($urandom_range(0, 1023));
      c  = ($urandom_range(0, 99) < 2);
      rr = ($urandom_range(0, 199) < 1);
      step(k, c, rr);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
